// File: rtl/sevenseg_scan_if.sv
// Display bus between the timekeeping chain (master) and the seven-segment scanner (slave).
// Digits and controls are level signals sampled every cycle; there is no valid/ready handshake.
interface sevenseg_scan_if;
    logic [3:0] d0;
    logic [2:0] d1;
    logic [3:0] d2;
    logic [2:0] d3;
    logic       blank;
    logic       colon_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       scan_tick;
    logic [1:0] dbg_sel;

    modport master (
        output d0, d1, d2, d3, blank, colon_en,
        input  seg, dp, an, scan_tick, dbg_sel
    );

    modport slave (
        input  d0, d1, d2, d3, blank, colon_en,
        output seg, dp, an, scan_tick, dbg_sel
    );
endinterface

// File: rtl/sevenseg_scan.sv
// Four-digit MM:SS common-anode seven-segment scanner: refresh divider, digit-select FSM, decoder.
// Optional macro LEAD_ZERO_BLANK_EN hides a leading zero in the minutes-tens digit.
module sevenseg_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16
) (
    input  logic           clk,
    input  logic           reset,
    sevenseg_scan_if.slave bus
);

    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} sel_t;

    sel_t             sel;
    logic [DIV_W-1:0] div;
    logic             div_last;
    logic [3:0]       digit;
    logic [3:0]       an_nx;
    logic [6:0]       seg_nx;
    logic             dp_nx;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic             tick_q;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign div_last = (div == DIV_W'(REFRESH_DIV - 1));

    always_comb begin
        digit = 4'd0;
        case (sel)
            S0:      digit = bus.d0;
            S1:      digit = {1'b0, bus.d1};
            S2:      digit = bus.d2;
            default: digit = {1'b0, bus.d3};
        endcase
    end

    // Output decode uses the slot currently selected, not the one about to start.
    always_comb begin
        an_nx  = bus.blank ? 4'b1111 : ~(4'b0001 << sel);
        seg_nx = decode(digit);
        dp_nx  = ~(bus.colon_en & (sel == S2) & ~bus.blank);
`ifdef LEAD_ZERO_BLANK_EN
        if (sel == S3 && bus.d3 == 3'd0) begin
            an_nx  = 4'b1111;
            seg_nx = 7'h7F;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div    <= '0;
            sel    <= S0;
            tick_q <= 1'b0;
            an_q   <= 4'b1111;
            seg_q  <= 7'h7F;
            dp_q   <= 1'b1;
        end else begin
            if (div_last) begin
                div    <= '0;
                tick_q <= 1'b1;
                case (sel)
                    S0:      sel <= S1;
                    S1:      sel <= S2;
                    S2:      sel <= S3;
                    default: sel <= S0;
                endcase
            end else begin
                div    <= div + 1'b1;
                tick_q <= 1'b0;
            end
            an_q  <= an_nx;
            seg_q <= seg_nx;
            dp_q  <= dp_nx;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.scan_tick = tick_q;
    assign bus.dbg_sel   = sel;

endmodule
